node_port: RTL

Node-side endpoint of the router core's packet interface: the other end of Packet_From_Node / Packet_To_Node.
- Buffers packets from the local host, offers them to router_core with a valid/ack handshake, and stamps the source address.
- Captures packets delivered by the core into a receive buffer for the host.
- Loops self-addressed packets back locally, so the token ring never carries them.
- Sits between the host logic and router_core in each node, clocked by Clk_R.

---
 rtl/rc_pkg.sv | 23 ++
 rtl/node_pkt_fifo.sv | 53 +++++
 rtl/node_port.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rc_pkg.sv
// Shared packet-format constants and TX state encoding for the node port.
package rc_pkg;

  localparam int PKT_W     = 29;
  localparam int ADDR_W    = 4;
  localparam int DEST_HI   = 28;
  localparam int DEST_LO   = 25;
  localparam int SRC_HI    = 24;
  localparam int SRC_LO    = 21;
  localparam int PAYLOAD_W = 21;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_OFFER   = 2'd1,
    TX_RELEASE = 2'd2
  } tx_state_e;

  // Destination field of a packet.
  function automatic logic [ADDR_W-1:0] pkt_dest(input logic [PKT_W-1:0] pkt);
    return pkt[DEST_HI:DEST_LO];
  endfunction

endpackage

// File: rtl/node_pkt_fifo.sv
// Synchronous packet FIFO with fall-through head and asynchronous clear.
// A push while full is accepted only when a pop happens in the same cycle.
module node_pkt_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             Clk_R,
  input  logic             Rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty stay distinct.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Head is forced to zero while empty so the output never shows stale data.
  assign dout = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update on accepted push/pop.
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the memory array is deliberately not reset; validity is tracked by the pointers alone.
  always_ff @(posedge Clk_R) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/node_port.sv
// Node-side endpoint of the router core packet interface: TX FIFO + offer
// handshake with source stamping, RX FIFO with drop counting, and local
// loopback of self-addressed packets.
module node_port
  import rc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] OUR_ADDRESS = 4'h0,
  parameter int                TX_DEPTH    = 4,
  parameter int                RX_DEPTH    = 4
) (
  input  logic             Clk_R,
  input  logic             Rst_n,
  input  logic [PKT_W-1:0] Host_Pkt_In,
  input  logic             Host_Pkt_In_Valid,
  output logic             Host_Pkt_In_Ready,
  output logic [PKT_W-1:0] Host_Pkt_Out,
  output logic             Host_Pkt_Out_Valid,
  input  logic             Host_Pkt_Out_Ready,
  output logic [PKT_W-1:0] Packet_From_Node,
  output logic             Packet_From_Node_Valid,
  input  logic             Core_Load_Ack,
  input  logic [PKT_W-1:0] Packet_To_Node,
  input  logic             Packet_To_Node_Valid,
  output logic [7:0]       Tx_Pkt_Cnt,
  output logic [7:0]       Rx_Drop_Cnt
);

  tx_state_e        r_state;
  logic [PKT_W-1:0] r_pfn;
  logic             r_pfn_valid;
  logic [7:0]       r_tx_cnt;
  logic [7:0]       r_drop_cnt;

  logic [PKT_W-1:0] w_tx_head;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic [PKT_W-1:0] w_rx_din;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_rx_push;
  logic             w_host_pop;
  logic             w_loopback;
  logic             w_offer_done;
  logic             w_rx_drop;
  logic             w_head_local;

  assign w_head_local = ~w_tx_empty && (pkt_dest(w_tx_head) == OUR_ADDRESS);

  // Core delivery always wins the RX write port; loopback waits for a free cycle.
  assign w_loopback   = (r_state == TX_IDLE) && w_head_local &&
                        ~w_rx_full && ~Packet_To_Node_Valid;
  assign w_offer_done = (r_state == TX_OFFER) && Core_Load_Ack;
  assign w_tx_pop     = w_loopback | w_offer_done;
  assign w_tx_push    = Host_Pkt_In_Valid & ~w_tx_full;

  assign w_host_pop   = Host_Pkt_Out_Ready & ~w_rx_empty;
  assign w_rx_push    = Packet_To_Node_Valid | w_loopback;
  assign w_rx_din     = Packet_To_Node_Valid ? Packet_To_Node : w_tx_head;
  assign w_rx_drop    = Packet_To_Node_Valid & w_rx_full & ~w_host_pop;

  assign Host_Pkt_In_Ready      = ~w_tx_full;
  assign Host_Pkt_Out_Valid     = ~w_rx_empty;
  assign Packet_From_Node       = r_pfn;
  assign Packet_From_Node_Valid = r_pfn_valid;
  assign Tx_Pkt_Cnt             = r_tx_cnt;
  assign Rx_Drop_Cnt            = r_drop_cnt;

  node_pkt_fifo #(.WIDTH(PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .Clk_R (Clk_R),
    .Rst_n (Rst_n),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (Host_Pkt_In),
    .dout  (w_tx_head),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  node_pkt_fifo #(.WIDTH(PKT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .Clk_R (Clk_R),
    .Rst_n (Rst_n),
    .push  (w_rx_push),
    .pop   (Host_Pkt_Out_Ready),
    .din   (w_rx_din),
    .dout  (Host_Pkt_Out),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  // TX offer FSM: load, hold until ack, then wait for ack to drop.
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= TX_IDLE;
      r_pfn       <= '0;
      r_pfn_valid <= 1'b0;
      r_tx_cnt    <= '0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (!w_tx_empty && !w_head_local) begin
            r_pfn       <= {w_tx_head[DEST_HI:DEST_LO], OUR_ADDRESS,
                            w_tx_head[PAYLOAD_W-1:0]};
            r_pfn_valid <= 1'b1;
            r_state     <= TX_OFFER;
          end
        end
        TX_OFFER: begin
          if (Core_Load_Ack) begin
            r_pfn_valid <= 1'b0;
            r_tx_cnt    <= r_tx_cnt + 8'd1;
            r_state     <= TX_RELEASE;
          end
        end
        TX_RELEASE: begin
          if (!Core_Load_Ack) r_state <= TX_IDLE;
        end
        default: begin
          r_pfn_valid <= 1'b0;
          r_state     <= TX_IDLE;
        end
      endcase
    end
  end

  // Saturating count of core deliveries lost to a full RX FIFO.
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_rx_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule
